regfile_wb_scheduler: RTL and testbench

- Shares the single register-file write port between two writeback requesters: A = ALU/immediate path, B = load unit.
- Tracks outstanding writes per architectural register in a scoreboard, so decode can stall on RAW hazards.
- Sits between execute/memory stages and the 32x32 register file. Drives its Reg_Write/W_ADDR/W_Data inputs from registered outputs.

---
 rtl/regfile_wb_scheduler_pkg.sv | 15 +
 rtl/regfile_wb_scheduler_wb_scoreboard.sv | 81 ++++++++
 rtl/regfile_wb_scheduler.sv | 121 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared definitions for the register-file writeback scheduler.
// Provides the architectural sizes and the grant encoding used by the arbiter.
package regfile_wb_scheduler_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;

  // Which requester won the write port most recently.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

endpackage

// File: rtl/regfile_wb_scheduler_wb_scoreboard.sv
// Per-register pending-write scoreboard.
// Ports:
//   clk_regs, rst_n        clock / async active-low reset
//   flush                  synchronous clear of all counters
//   iss_valid/iss_addr     decode issues a destination register
//   iss_ready              counter for iss_addr is not saturated
//   ret_valid/ret_addr     a write to a non-zero register left through the write port
//   rs1_addr/rs2_addr      source lookups; rs1_busy/rs2_busy report pending writes
//   sb_err                 sticky: a write retired against a zero counter
module regfile_wb_scheduler_wb_scoreboard
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int unsigned PEND_W = 2
) (
  input  logic                  clk_regs,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_addr,
  output logic                  iss_ready,
  input  logic                  ret_valid,
  input  logic [REG_ADDR_W-1:0] ret_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  sb_err
);

  localparam logic [PEND_W-1:0] CntMax = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] CntOne = PEND_W'(1);

  logic [PEND_W-1:0] cnt_q [NUM_REGS];
  logic [PEND_W-1:0] cnt_d [NUM_REGS];
  logic              sb_err_q, sb_err_d;
  logic              iss_fire;

  assign iss_ready = (iss_addr == '0) || (cnt_q[iss_addr] != CntMax);
  assign iss_fire  = iss_valid && iss_ready && (iss_addr != '0);

  // cnt_q[0] is held at zero, so x0 never reads as busy.
  assign rs1_busy = (cnt_q[rs1_addr] != '0);
  assign rs2_busy = (cnt_q[rs2_addr] != '0);
  assign sb_err   = sb_err_q;

  always_comb begin
    sb_err_d = sb_err_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0 || flush) begin
        // Flush discards both same-cycle issues and retirements.
        cnt_d[r] = '0;
      end else if (iss_fire && (iss_addr == r[REG_ADDR_W-1:0]) &&
                   !(ret_valid && (ret_addr == r[REG_ADDR_W-1:0]))) begin
        cnt_d[r] = cnt_q[r] + CntOne;
      end else if (ret_valid && (ret_addr == r[REG_ADDR_W-1:0]) &&
                   !(iss_fire && (iss_addr == r[REG_ADDR_W-1:0]))) begin
        if (cnt_q[r] == '0) begin
          sb_err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CntOne;
        end
      end
    end
  end

  always_ff @(posedge clk_regs or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      sb_err_q <= sb_err_d;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: arbitrates two writeback requesters
// (A = ALU/immediate, B = load unit) onto the single register-file write port
// and tracks outstanding writes per register for RAW-hazard stalls.
// Ports:
//   clk_regs, rst_n                   clock / async active-low reset
//   a_valid/a_addr/a_data/a_ready     requester A handshake
//   b_valid/b_addr/b_data/b_ready     requester B handshake
//   iss_valid/iss_addr/iss_ready      decode destination issue
//   flush                             clear scoreboard
//   rs1_addr/rs2_addr, rs1_busy/rs2_busy  source hazard lookups
//   Reg_Write/W_ADDR/W_Data           registered register-file write port
//   sb_err                            sticky scoreboard underflow flag
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned PEND_W     = 2
) (
  input  logic                  clk_regs,
  input  logic                  rst_n,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [XLEN-1:0]       a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [XLEN-1:0]       b_data,
  output logic                  b_ready,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_addr,
  output logic                  iss_ready,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  Reg_Write,
  output logic [REG_ADDR_W-1:0] W_ADDR,
  output logic [XLEN-1:0]       W_Data,
  output logic                  sb_err
);

  req_e                  last_grant_q, last_grant_d;
  logic                  grant_a, grant_b, xfer;
  logic [REG_ADDR_W-1:0] xfer_addr;
  logic [XLEN-1:0]       xfer_data;
  logic                  reg_write_q;
  logic [REG_ADDR_W-1:0] w_addr_q;
  logic [XLEN-1:0]       w_data_q;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_valid && b_valid) begin
      // On a tie the requester that did not win last time goes next.
      if (FIXED_PRIO != 0 || last_grant_q == REQ_B) begin
        grant_a = 1'b1;
      end else begin
        grant_b = 1'b1;
      end
    end else begin
      grant_a = a_valid;
      grant_b = b_valid;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_a) begin
      last_grant_d = REQ_A;
    end else if (grant_b) begin
      last_grant_d = REQ_B;
    end
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign xfer      = grant_a || grant_b;
  assign xfer_addr = grant_a ? a_addr : b_addr;
  assign xfer_data = grant_a ? a_data : b_data;

  always_ff @(posedge clk_regs or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= REQ_B;
      reg_write_q  <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      // Writes to x0 are accepted but never enable the register file.
      reg_write_q  <= xfer && (xfer_addr != '0);
      if (xfer) begin
        w_addr_q <= xfer_addr;
        w_data_q <= xfer_data;
      end
    end
  end

  assign Reg_Write = reg_write_q;
  assign W_ADDR    = w_addr_q;
  assign W_Data    = w_data_q;

  regfile_wb_scheduler_wb_scoreboard #(
    .PEND_W (PEND_W)
  ) u_scoreboard (
    .clk_regs  (clk_regs),
    .rst_n     (rst_n),
    .flush     (flush),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .ret_valid (xfer && (xfer_addr != '0)),
    .ret_addr  (xfer_addr),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .sb_err    (sb_err)
  );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: a round-robin instance checked every cycle
// against a behavioural model, plus a fixed-priority instance checked directly.
module tb_regfile_wb_scheduler;

  logic        clk_regs = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, iss_valid, flush;
  logic [4:0]  a_addr, b_addr, iss_addr, rs1_addr, rs2_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, iss_ready, rs1_busy, rs2_busy, Reg_Write, sb_err;
  logic [4:0]  W_ADDR;
  logic [31:0] W_Data;
  logic        p1_a_ready, p1_b_ready, p1_iss_ready, p1_rs1_busy, p1_rs2_busy;
  logic        p1_Reg_Write, p1_sb_err;
  logic [4:0]  p1_W_ADDR;
  logic [31:0] p1_W_Data;

  always #5 clk_regs = ~clk_regs;

  regfile_wb_scheduler #(.FIXED_PRIO(0), .PEND_W(2)) dut (
    .clk_regs(clk_regs), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .Reg_Write(Reg_Write), .W_ADDR(W_ADDR), .W_Data(W_Data), .sb_err(sb_err)
  );

  regfile_wb_scheduler #(.FIXED_PRIO(1), .PEND_W(2)) dut_fixed (
    .clk_regs(clk_regs), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(p1_a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(p1_b_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(p1_iss_ready), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(p1_rs1_busy), .rs2_busy(p1_rs2_busy),
    .Reg_Write(p1_Reg_Write), .W_ADDR(p1_W_ADDR), .W_Data(p1_W_Data), .sb_err(p1_sb_err)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending-write counts, sticky error, last winner, write port.
  int          m_cnt [32];
  bit          m_err, m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_last;  // 0 = A won last, 1 = B won last
  bit          ga, gb, ir;
  logic [4:0]  xa;
  logic [31:0] xd;

  always @(negedge clk_regs) begin
    if (!rst_n) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_err = 0; m_we = 0; m_addr = '0; m_data = '0; m_last = 1;
      check("rst_reg_write", Reg_Write, 0);
      check("rst_w_addr", W_ADDR, 0);
      check("rst_w_data", W_Data, 0);
      check("rst_sb_err", sb_err, 0);
    end else begin
      ga = a_valid && (!b_valid || m_last == 1);
      gb = b_valid && !ga;
      ir = (iss_addr == 0) || (m_cnt[iss_addr] < 3);
      check("m_a_ready", a_ready, ga);
      check("m_b_ready", b_ready, gb);
      check("m_iss_ready", iss_ready, ir);
      check("m_rs1_busy", rs1_busy, m_cnt[rs1_addr] > 0);
      check("m_rs2_busy", rs2_busy, m_cnt[rs2_addr] > 0);
      check("m_reg_write", Reg_Write, m_we);
      check("m_w_addr", W_ADDR, m_addr);
      check("m_w_data", W_Data, m_data);
      check("m_sb_err", sb_err, m_err);
      xa = ga ? a_addr : b_addr;
      xd = ga ? a_data : b_data;
      if (ga || gb) begin
        m_last = ga ? 0 : 1;
        m_addr = xa;
        m_data = xd;
        m_we   = (xa != 0);
      end else begin
        m_we = 0;
      end
      if (flush) begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
      end else begin
        if (iss_valid && ir && iss_addr != 0) m_cnt[iss_addr]++;
        if ((ga || gb) && xa != 0) begin
          if (m_cnt[xa] == 0) m_err = 1;
          else m_cnt[xa]--;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_regs);
    #1;
  endtask

  task automatic idle();
    a_valid = 0; a_addr = '0; a_data = '0;
    b_valid = 0; b_addr = '0; b_data = '0;
    iss_valid = 0; iss_addr = '0; flush = 0;
    rs1_addr = '0; rs2_addr = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    idle();
    step();
    step();
    rst_n = 1;

    // Single A write to x5.
    a_valid = 1; a_addr = 5'd5; a_data = 32'h1234_5678;
    #1 check("a_ready_first", a_ready, 1);
    step();
    idle();
    check("first_reg_write", Reg_Write, 1);
    check("first_w_addr", W_ADDR, 5);
    check("first_w_data", W_Data, 32'h1234_5678);

    // Both requesters valid every cycle.
    do_reset();
    a_valid = 1; a_addr = 5'd3; a_data = 32'hA;
    b_valid = 1; b_addr = 5'd4; b_data = 32'hB;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_a_ready", a_ready, (i % 2) == 0);
      check("rr_b_ready", b_ready, (i % 2) == 1);
      check("fixed_a_ready", p1_a_ready, 1);
      check("fixed_b_ready", p1_b_ready, 0);
      step();
    end

    // x7 issued twice, retired twice.
    do_reset();
    iss_valid = 1; iss_addr = 5'd7;
    #1 check("x7_iss_ready", iss_ready, 1);
    step();
    step();
    iss_valid = 0; rs1_addr = 5'd7;
    #1 check("x7_busy_issued", rs1_busy, 1);
    a_valid = 1; a_addr = 5'd7; a_data = 32'h77;
    step();
    a_valid = 0;
    #1 check("x7_busy_one_left", rs1_busy, 1);
    a_valid = 1;
    step();
    a_valid = 0;
    #1 check("x7_busy_clear", rs1_busy, 0);
    check("x7_reg_write", Reg_Write, 1);

    // x9 saturation and same-cycle issue plus retire.
    iss_valid = 1; iss_addr = 5'd9; rs2_addr = 5'd9;
    step();
    step();
    step();
    #1 check("x9_saturated", iss_ready, 0);
    iss_valid = 0;
    a_valid = 1; a_addr = 5'd9; a_data = 32'h99;
    step();
    iss_valid = 1;
    #1 check("x9_ready_after_ret", iss_ready, 1);
    step();
    iss_valid = 0; a_valid = 0;
    #1 check("x9_busy_after_both", rs2_busy, 1);
    check("x9_ready_after_both", iss_ready, 1);
    iss_valid = 1;
    step();
    iss_valid = 0;
    #1 check("x9_resaturated", iss_ready, 0);
    check("no_err_yet", sb_err, 0);

    // Write to x0, then an unmatched write to x10.
    a_valid = 1; a_addr = 5'd0; a_data = 32'hFFFF_FFFF;
    #1 check("x0_a_ready", a_ready, 1);
    step();
    a_valid = 0;
    #1 check("x0_no_reg_write", Reg_Write, 0);
    check("x0_w_data", W_Data, 32'hFFFF_FFFF);
    check("x0_no_err", sb_err, 0);
    a_valid = 1; a_addr = 5'd10; a_data = 32'h10;
    step();
    a_valid = 0;
    #1 check("x10_reg_write", Reg_Write, 1);
    check("x10_err_set", sb_err, 1);
    step();
    step();
    check("x10_err_sticky", sb_err, 1);

    // Flush wins over a same-cycle issue; same-cycle transfer still writes.
    do_reset();
    iss_valid = 1; iss_addr = 5'd2;
    step();
    iss_addr = 5'd3;
    step();
    iss_valid = 0; rs1_addr = 5'd2; rs2_addr = 5'd3;
    #1 check("pre_flush_busy1", rs1_busy, 1);
    check("pre_flush_busy2", rs2_busy, 1);
    flush = 1; iss_valid = 1; iss_addr = 5'd4;
    a_valid = 1; a_addr = 5'd2; a_data = 32'h22;
    step();
    idle();
    rs1_addr = 5'd2; rs2_addr = 5'd4; iss_addr = 5'd2;
    #1 check("flush_busy_x2", rs1_busy, 0);
    check("flush_busy_x4", rs2_busy, 0);
    check("flush_iss_ready", iss_ready, 1);
    check("flush_reg_write", Reg_Write, 1);
    check("flush_w_addr", W_ADDR, 2);
    check("flush_no_err", sb_err, 0);
    rs2_addr = 5'd3;
    #1 check("flush_busy_x3", rs2_busy, 0);

    // Reset while a write is being presented.
    a_valid = 1; a_addr = 5'd5; a_data = 32'h55;
    step();
    a_valid = 0;
    #1 check("pre_reset_reg_write", Reg_Write, 1);
    rst_n = 0;
    #1 check("async_reset_reg_write", Reg_Write, 0);
    check("async_reset_w_data", W_Data, 0);
    step();
    step();
    rst_n = 1;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
